// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the 2-bit adder stage, the result accumulator and
// the consumer of batch totals.
interface adder_result_accumulator_if #(
  parameter int ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_sum;
  logic                 in_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_overflow;

  // The producer/consumer side drives operands and takes totals.
  modport master (
    output in_valid,
    output in_sum,
    output in_carry,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_overflow,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_sum,
    input  in_carry,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_overflow,
    input  out_ready
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums BATCH adder results ({carry, sum1, sum0}) into a saturating accumulator
// and offers the batch total on a valid/ready port until it is taken.
module adder_result_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int BATCH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  output logic                      busy,
  adder_result_accumulator_if.slave bus
);

  localparam int CW = $clog2(BATCH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [CW-1:0]        count_inc;

  assign bus.in_ready = (state_q != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign operand      = ACC_WIDTH'({bus.in_carry, bus.in_sum});
  assign sum_wide     = {1'b0, acc_q} + {1'b0, operand};
  assign count_inc    = count_q + CW'(1);

  // Next-state decode; clear overrides everything, including a coincident
  // accept or a coincident out_ready while holding.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = operand;
            count_d = CW'(1);
            ovf_d   = 1'b0;
            state_d = (BATCH == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sum_wide[ACC_WIDTH]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_wide[ACC_WIDTH-1:0];
            end
            count_d = count_inc;
            if (count_inc == CW'(BATCH)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // Output registers follow the next state so the total only ever appears
  // alongside out_valid, never as a partial sum.
  always_comb begin
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d == ACCUM);
    out_acc_d   = '0;
    out_ovf_d   = 1'b0;
    if (state_d == HOLD) begin
      out_acc_d = acc_d;
      out_ovf_d = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_acc      = out_acc_q;
  assign bus.out_overflow = out_ovf_q;
  assign busy             = busy_q;

endmodule
